// File: rtl/psk_rx_deframer.sv
// psk_rx_deframer
//   Searches the demodulated serial bit stream for a 32-bit sync word (or its
//   complement, resolving the BPSK 180-degree ambiguity), reads a one-byte
//   length header and emits the payload as a tready-less byte stream.
//
// Ports:
//   clk_16M384   system clock
//   rst_16M384   asynchronous active-high reset
//   bit_in       demodulated hard bit, sampled when bit_vld=1
//   bit_vld      one-cycle strobe per received bit
//   sd_active    signal detect; 0 aborts a frame in progress
//   data_tdata   payload byte, MSB = first received bit
//   data_tvalid  one-cycle pulse per byte
//   data_tuser   first byte of a frame
//   data_tlast   last byte of a frame
//   locked       high from sync hit until frame end or abort
//   inverted     polarity of the current/last frame (1 = complemented sync)
//   frame_err    one-cycle pulse on zero-length header or abort
//   frame_cnt    completed-frame count, wraps
module psk_rx_deframer #(
   parameter logic [31:0] SYNC_WORD = 32'h1ACFFC1D,
   parameter int unsigned MAX_ERR   = 2
) (
   input  logic        clk_16M384,
   input  logic        rst_16M384,
   input  logic        bit_in,
   input  logic        bit_vld,
   input  logic        sd_active,
   output logic [7:0]  data_tdata,
   output logic        data_tvalid,
   output logic        data_tuser,
   output logic        data_tlast,
   output logic        locked,
   output logic        inverted,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   localparam logic [1:0] HUNT    = 2'd0;
   localparam logic [1:0] HEADER  = 2'd1;
   localparam logic [1:0] PAYLOAD = 2'd2;

   localparam logic [5:0] MaxErr = 6'(MAX_ERR);

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
      return c;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [31:0] sr_q, sr_d;
   logic [5:0]  hunt_cnt_q, hunt_cnt_d;   // bits shifted since HUNT entry, saturates at 32
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  acc_q, acc_d;
   logic [7:0]  byte_rem_q, byte_rem_d;
   logic        first_q, first_d;
   logic [7:0]  tdata_q, tdata_d;
   logic        tvalid_q, tvalid_d;
   logic        tuser_q, tuser_d;
   logic        tlast_q, tlast_d;
   logic        locked_q, locked_d;
   logic        inverted_q, inverted_d;
   logic        frame_err_q, frame_err_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic [31:0] sr_next;
   logic [7:0]  acc_next;
   logic [5:0]  d0, d1;

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      hunt_cnt_d  = hunt_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      acc_d       = acc_q;
      byte_rem_d  = byte_rem_q;
      first_d     = first_q;
      tdata_d     = tdata_q;
      tvalid_d    = 1'b0;
      tuser_d     = 1'b0;
      tlast_d     = 1'b0;
      locked_d    = locked_q;
      inverted_d  = inverted_q;
      frame_err_d = 1'b0;
      frame_cnt_d = frame_cnt_q;

      sr_next  = {sr_q[30:0], bit_in};
      d0       = popcount32(sr_next ^ SYNC_WORD);
      d1       = popcount32(sr_next ^ ~SYNC_WORD);
      acc_next = {acc_q[6:0], bit_in ^ inverted_q};

      unique case (state_q)
         HUNT: begin
            if (!sd_active) begin
               sr_d       = '0;
               hunt_cnt_d = '0;
            end else if (bit_vld) begin
               sr_d = sr_next;
               if (hunt_cnt_q != 6'd32) hunt_cnt_d = hunt_cnt_q + 6'd1;
               // This bit is the 32nd or later since the register was cleared
               if (hunt_cnt_q >= 6'd31) begin
                  if (d0 <= MaxErr) begin
                     inverted_d = 1'b0;
                     locked_d   = 1'b1;
                     bit_cnt_d  = '0;
                     state_d    = HEADER;
                  end else if (d1 <= MaxErr) begin
                     inverted_d = 1'b1;
                     locked_d   = 1'b1;
                     bit_cnt_d  = '0;
                     state_d    = HEADER;
                  end
               end
            end
         end
         HEADER, PAYLOAD: begin
            if (!sd_active) begin
               // Abort: partial byte discarded, no tlast
               frame_err_d = 1'b1;
               locked_d    = 1'b0;
               sr_d        = '0;
               hunt_cnt_d  = '0;
               bit_cnt_d   = '0;
               state_d     = HUNT;
            end else if (bit_vld) begin
               acc_d     = acc_next;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (state_q == HEADER) begin
                     if (acc_next == 8'd0) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        sr_d        = '0;
                        hunt_cnt_d  = '0;
                        state_d     = HUNT;
                     end else begin
                        byte_rem_d = acc_next;
                        first_d    = 1'b1;
                        state_d    = PAYLOAD;
                     end
                  end else begin
                     tvalid_d   = 1'b1;
                     tdata_d    = acc_next;
                     tuser_d    = first_q;
                     tlast_d    = (byte_rem_q == 8'd1);
                     first_d    = 1'b0;
                     byte_rem_d = byte_rem_q - 8'd1;
                     if (byte_rem_q == 8'd1) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        locked_d    = 1'b0;
                        sr_d        = '0;
                        hunt_cnt_d  = '0;
                        state_d     = HUNT;
                     end
                  end
               end
            end
         end
         default: begin
            state_d    = HUNT;
            sr_d       = '0;
            hunt_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
      if (rst_16M384) begin
         state_q     <= HUNT;
         sr_q        <= '0;
         hunt_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         acc_q       <= '0;
         byte_rem_q  <= '0;
         first_q     <= 1'b0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tuser_q     <= 1'b0;
         tlast_q     <= 1'b0;
         locked_q    <= 1'b0;
         inverted_q  <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         hunt_cnt_q  <= hunt_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         acc_q       <= acc_d;
         byte_rem_q  <= byte_rem_d;
         first_q     <= first_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tuser_q     <= tuser_d;
         tlast_q     <= tlast_d;
         locked_q    <= locked_d;
         inverted_q  <= inverted_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign data_tdata  = tdata_q;
   assign data_tvalid = tvalid_q;
   assign data_tuser  = tuser_q;
   assign data_tlast  = tlast_q;
   assign locked      = locked_q;
   assign inverted    = inverted_q;
   assign frame_err   = frame_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_psk_rx_deframer.sv
// Directed bench for psk_rx_deframer: clean, inverted, bit-error, zero-length,
// abort and mid-frame reset scenarios at one bit per 16 clocks.
module tb_psk_rx_deframer;

   localparam logic [31:0] SYNC = 32'h1ACFFC1D;

   logic        clk, rst, bit_in, bit_vld, sd_active;
   logic [7:0]  data_tdata;
   logic        data_tvalid, data_tuser, data_tlast;
   logic        locked, inverted, frame_err;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] cap_data [0:63];
   logic       cap_user [0:63];
   logic       cap_last [0:63];
   int         ncap  = 0;
   int         nferr = 0;
   int         n0, e0;

   psk_rx_deframer #(
      .SYNC_WORD (SYNC),
      .MAX_ERR   (2)
   ) dut (
      .clk_16M384  (clk),
      .rst_16M384  (rst),
      .bit_in      (bit_in),
      .bit_vld     (bit_vld),
      .sd_active   (sd_active),
      .data_tdata  (data_tdata),
      .data_tvalid (data_tvalid),
      .data_tuser  (data_tuser),
      .data_tlast  (data_tlast),
      .locked      (locked),
      .inverted    (inverted),
      .frame_err   (frame_err),
      .frame_cnt   (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Capture output pulses mid-cycle
   always @(negedge clk) begin
      if (data_tvalid && ncap < 64) begin
         cap_data[ncap] <= data_tdata;
         cap_user[ncap] <= data_tuser;
         cap_last[ncap] <= data_tlast;
         ncap           <= ncap + 1;
      end
      if (frame_err) nferr <= nferr + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(posedge clk);
      #1;
      bit_in  = b;
      bit_vld = 1'b1;
      @(posedge clk);
      #1;
      bit_vld = 1'b0;
      repeat (14) @(posedge clk);
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic inv);
      send_bits({24'd0, b ^ {8{inv}}}, 8);
   endtask

   // Sync, length header, then len bytes taken MSB-byte first from data
   task automatic send_frame(input logic [31:0] sync, input logic inv, input logic [7:0] len,
                             input logic [31:0] data);
      send_bits(sync ^ {32{inv}}, 32);
      send_byte(len, inv);
      for (int k = 0; k < int'(len); k++) send_byte(data[31-8*k -: 8], inv);
   endtask

   initial begin
      rst       = 1'b1;
      bit_in    = 1'b0;
      bit_vld   = 1'b0;
      sd_active = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", data_tvalid, 0);
      check("rst_tdata", data_tdata, 0);
      check("rst_locked", locked, 0);
      check("rst_cnt", frame_cnt, 0);
      check("rst_ferr", frame_err, 0);
      rst = 1'b0;

      // Clean frame with an exact latency check on the final byte
      n0 = ncap; e0 = nferr;
      send_bits(SYNC, 32);
      check("clean_locked", locked, 1);
      check("clean_inv", inverted, 0);
      send_byte(8'd3, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h3C, 1'b0);
      send_bits(32'h07, 7);
      @(posedge clk);
      #1;
      bit_in  = 1'b1;
      bit_vld = 1'b1;
      check("lat_pre", data_tvalid, 0);
      @(posedge clk);
      #1;
      bit_vld = 1'b0;
      check("lat_tvalid", data_tvalid, 1);
      check("lat_tdata", data_tdata, 8'h0F);
      check("lat_tlast", data_tlast, 1);
      check("lat_tuser", data_tuser, 0);
      @(posedge clk);
      #1;
      check("lat_post", data_tvalid, 0);
      repeat (13) @(posedge clk);
      check("clean_n", ncap - n0, 3);
      check("clean_b0", cap_data[n0], 8'hA5);
      check("clean_b1", cap_data[n0+1], 8'h3C);
      check("clean_b2", cap_data[n0+2], 8'h0F);
      check("clean_u", {cap_user[n0], cap_user[n0+1], cap_user[n0+2]}, 3'b100);
      check("clean_l", {cap_last[n0], cap_last[n0+1], cap_last[n0+2]}, 3'b001);
      check("clean_cnt", frame_cnt, 1);
      check("clean_unlock", locked, 0);
      check("clean_ferr", nferr - e0, 0);

      // Complemented stream
      n0 = ncap;
      send_frame(SYNC, 1'b1, 8'd3, 32'hA53C0F00);
      check("inv_inv", inverted, 1);
      check("inv_n", ncap - n0, 3);
      check("inv_b0", cap_data[n0], 8'hA5);
      check("inv_b1", cap_data[n0+1], 8'h3C);
      check("inv_b2", cap_data[n0+2], 8'h0F);
      check("inv_cnt", frame_cnt, 2);

      // Two sync bit errors: accepted
      n0 = ncap;
      send_frame(SYNC ^ 32'h80000001, 1'b0, 8'd1, 32'h55000000);
      check("err2_n", ncap - n0, 1);
      check("err2_b0", cap_data[n0], 8'h55);
      check("err2_inv", inverted, 0);
      check("err2_cnt", frame_cnt, 3);

      // Three sync bit errors: rejected
      n0 = ncap; e0 = nferr;
      send_bits(SYNC ^ 32'h00810004, 32);
      check("err3_locked", locked, 0);
      send_bits(32'd0, 32);
      check("err3_n", ncap - n0, 0);
      check("err3_cnt", frame_cnt, 3);
      check("err3_ferr", nferr - e0, 0);

      // Zero-length header, then a single-byte frame
      n0 = ncap; e0 = nferr;
      send_bits(SYNC, 32);
      send_byte(8'd0, 1'b0);
      check("zl_ferr", nferr - e0, 1);
      check("zl_n", ncap - n0, 0);
      check("zl_locked", locked, 0);
      send_frame(SYNC, 1'b0, 8'd1, 32'h7E000000);
      check("one_n", ncap - n0, 1);
      check("one_b0", cap_data[n0], 8'h7E);
      check("one_ul", {cap_user[n0], cap_last[n0]}, 2'b11);
      check("one_cnt", frame_cnt, 4);

      // Abort after 1.5 bytes of a len=4 frame
      n0 = ncap; e0 = nferr;
      send_bits(SYNC, 32);
      send_byte(8'd4, 1'b0);
      send_byte(8'h12, 1'b0);
      send_bits(32'h3, 4);
      check("ab_pre_locked", locked, 1);
      @(posedge clk);
      #1;
      sd_active = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ab_locked", locked, 0);
      check("ab_ferr", nferr - e0, 1);
      check("ab_n", ncap - n0, 1);
      check("ab_b0", cap_data[n0], 8'h12);
      check("ab_ul", {cap_user[n0], cap_last[n0]}, 2'b10);
      check("ab_cnt", frame_cnt, 4);
      sd_active = 1'b1;
      n0 = ncap;
      send_frame(SYNC, 1'b0, 8'd2, 32'hC3990000);
      check("ab2_n", ncap - n0, 2);
      check("ab2_b0", cap_data[n0], 8'hC3);
      check("ab2_b1", cap_data[n0+1], 8'h99);
      check("ab2_u", {cap_user[n0], cap_user[n0+1]}, 2'b10);
      check("ab2_l", {cap_last[n0], cap_last[n0+1]}, 2'b01);
      check("ab2_cnt", frame_cnt, 5);

      // Asynchronous reset in the middle of an inverted frame
      send_bits(~SYNC, 32);
      send_byte(8'd3, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_bits(32'h2, 3);
      check("rm_pre_locked", locked, 1);
      check("rm_pre_inv", inverted, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rm_locked", locked, 0);
      check("rm_inv", inverted, 0);
      check("rm_tdata", data_tdata, 0);
      check("rm_cnt", frame_cnt, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n0 = ncap;
      send_frame(SYNC, 1'b0, 8'd1, 32'h3C000000);
      check("rm2_n", ncap - n0, 1);
      check("rm2_b0", cap_data[n0], 8'h3C);
      check("rm2_cnt", frame_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
